// File: rtl/branch_predict_unit.sv
// Branch resolution and fetch-side prediction for the 6-stage core.
// Conditional branches, jal and jalr are resolved in EX from the ALU flags.
// A mispredict raises flush together with the correct next PC.
// Fetch prediction uses a bimodal table of 2-bit saturating counters
// and a direct-mapped BTB. Both are read combinationally at if_pc.
// The block also keeps saturating branch and mispredict counters.
module branch_predict_unit #(
    parameter int         XLEN        = 32,
    parameter int         BHT_ENTRIES = 64,
    parameter int         BTB_ENTRIES = 16,
    parameter logic [1:0] CNT_INIT    = 2'b01
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_branch,
    input  logic            ex_jump,
    input  logic            ex_jalr,
    input  logic [2:0]      ex_funct3,
    input  logic            N,
    input  logic            Z,
    input  logic            C,
    input  logic            V,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    input  logic [XLEN-1:0] ex_br_target,
    input  logic [XLEN-1:0] ex_jalr_target,
    input  logic [XLEN-1:0] ex_pc_plus4,
    output logic            btaken,
    output logic [1:0]      pc_src,
    output logic            flush,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     br_count,
    output logic [31:0]     mp_count
);

    localparam int BW   = $clog2(BHT_ENTRIES);
    localparam int TW   = $clog2(BTB_ENTRIES);
    localparam int TAGW = XLEN - TW - 2;

    logic [1:0]      bht        [BHT_ENTRIES];
    logic            btb_valid  [BTB_ENTRIES];
    logic [TAGW-1:0] btb_tag    [BTB_ENTRIES];
    logic [XLEN-1:0] btb_target [BTB_ENTRIES];
    logic            btb_jump   [BTB_ENTRIES];

    logic [BW-1:0]   if_bidx;
    logic [TW-1:0]   if_tidx;
    logic [TAGW-1:0] if_tag;
    logic [BW-1:0]   ex_bidx;
    logic [TW-1:0]   ex_tidx;
    logic [TAGW-1:0] ex_tag;
    logic            btb_hit;

    logic            cond;
    logic            br_taken;
    logic            actual_taken;
    logic [XLEN-1:0] actual_target;
    logic            is_ctrl;
    logic            mispredict;
    logic            res_active;
    logic            btb_we;

    // The two byte-offset bits of the PCs never take part in indexing.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

    assign if_bidx = if_pc[BW+1:2];
    assign if_tidx = if_pc[TW+1:2];
    assign if_tag  = if_pc[XLEN-1:TW+2];
    assign ex_bidx = ex_pc[BW+1:2];
    assign ex_tidx = ex_pc[TW+1:2];
    assign ex_tag  = ex_pc[XLEN-1:TW+2];

    assign btb_hit = btb_valid[if_tidx] && (btb_tag[if_tidx] == if_tag);

    // Fetch prediction; reads pre-update state, so a same-cycle write shows up next cycle.
    always_comb begin
        pred_taken  = 1'b0;
        pred_target = '0;
        if (rst_n && btb_hit) begin
            pred_taken  = btb_jump[if_tidx] | bht[if_bidx][1];
            pred_target = btb_target[if_tidx];
        end
    end

    // Branch condition from the SrcA-SrcB flags; C set means no borrow.
    always_comb begin
        cond = 1'b0;
        case (ex_funct3)
            3'b000:  cond = Z;
            3'b001:  cond = ~Z;
            3'b100:  cond = N ^ V;
            3'b101:  cond = ~(N ^ V);
            3'b110:  cond = ~C;
            3'b111:  cond = C;
            default: cond = 1'b0;
        endcase
    end

    assign res_active    = rst_n & ex_valid;
    assign is_ctrl       = ex_branch | ex_jump | ex_jalr;
    assign br_taken      = ex_branch & cond;
    assign actual_taken  = br_taken | ex_jump | ex_jalr;
    assign actual_target = ex_jalr ? ex_jalr_target : ex_br_target;
    assign mispredict    = is_ctrl &&
                           ((actual_taken != ex_pred_taken) ||
                            (actual_taken && ex_pred_taken && (ex_pred_target != actual_target)));
    // jalr is deliberately never allocated; its target depends on rs1.
    assign btb_we        = br_taken | ex_jump;

    // Resolve outputs are forced to zero when EX is empty or in reset.
    always_comb begin
        btaken      = 1'b0;
        pc_src      = 2'b00;
        flush       = 1'b0;
        redirect_pc = '0;
        if (res_active) begin
            btaken      = br_taken;
            flush       = mispredict;
            redirect_pc = actual_taken ? actual_target : ex_pc_plus4;
            if (ex_jump || br_taken) begin
                pc_src = 2'b01;
            end else if (ex_jalr) begin
                pc_src = 2'b10;
            end
        end
    end

    // Bimodal counters: train on every resolved conditional branch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= CNT_INIT;
            end
        end else if (ex_valid && ex_branch) begin
            if (br_taken) begin
                if (bht[ex_bidx] != 2'b11) begin
                    bht[ex_bidx] <= bht[ex_bidx] + 2'b01;
                end
            end else if (bht[ex_bidx] != 2'b00) begin
                bht[ex_bidx] <= bht[ex_bidx] - 2'b01;
            end
        end
    end

    // BTB valid bits: cleared on reset, set on allocation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid[i] <= 1'b0;
            end
        end else if (ex_valid && btb_we) begin
            btb_valid[ex_tidx] <= 1'b1;
        end
    end

    // BTB payload: taken branches and jal overwrite whatever sits at the index.
    always_ff @(posedge clk) begin
        if (rst_n && ex_valid && btb_we) begin
            btb_tag[ex_tidx]    <= ex_tag;
            btb_target[ex_tidx] <= ex_br_target;
            btb_jump[ex_tidx]   <= ex_jump;
        end
    end

    // Performance counters, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            br_count <= '0;
            mp_count <= '0;
        end else if (ex_valid) begin
            if (is_ctrl && (br_count != 32'hFFFF_FFFF)) begin
                br_count <= br_count + 32'd1;
            end
            if (mispredict && (mp_count != 32'hFFFF_FFFF)) begin
                mp_count <= mp_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: a driver issues stimulus and
// pushes expected responses computed from a behavioural model; a monitor
// pops and compares against the DUT outputs every cycle.
module tb_branch_predict_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_branch, ex_jump, ex_jalr;
    logic [2:0]  ex_funct3;
    logic        N, Z, C, V;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target, ex_br_target, ex_jalr_target, ex_pc_plus4;
    logic        btaken;
    logic [1:0]  pc_src;
    logic        flush;
    logic [31:0] redirect_pc, br_count, mp_count;

    branch_predict_unit dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_jalr(ex_jalr),
        .ex_funct3(ex_funct3), .N(N), .Z(Z), .C(C), .V(V),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .ex_br_target(ex_br_target), .ex_jalr_target(ex_jalr_target),
        .ex_pc_plus4(ex_pc_plus4),
        .btaken(btaken), .pc_src(pc_src), .flush(flush),
        .redirect_pc(redirect_pc), .br_count(br_count), .mp_count(mp_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          pt;
        logic [31:0] ptg;
        bit          bt;
        logic [1:0]  ps;
        bit          fl;
        logic [31:0] rp;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t q[$];
    int   tests  = 0;
    int   failed = 0;

    // Reference model: counters as integers 0..3, BTB keeps the whole PC.
    int          m_bht [64];
    bit          m_v   [16];
    logic [31:0] m_pc  [16];
    logic [31:0] m_tg  [16];
    bit          m_j   [16];
    logic [31:0] m_bc, m_mc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_bht[i] = 1;
        for (int i = 0; i < 16; i++) m_v[i] = 0;
        m_bc = 0;
        m_mc = 0;
    endtask

    task automatic model_pred(input logic [31:0] pc, output bit tk, output logic [31:0] tg);
        int t, bi;
        t  = (pc / 4) % 16;
        bi = (pc / 4) % 64;
        tk = 0;
        tg = 0;
        if (m_v[t] && ((m_pc[t] >> 6) == (pc >> 6))) begin
            tk = m_j[t] || (m_bht[bi] >= 2);
            tg = m_tg[t];
        end
    endtask

    task automatic step(input bit rst, input logic [31:0] ipc, input bit v, input logic [31:0] pc,
                        input bit br, input bit jmp, input bit jr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b, input bit ptk,
                        input logic [31:0] ptg, input logic [31:0] brt, input logic [31:0] jrt);
        logic [31:0] d, atg;
        bit          cnd, at, fl, ctrl;
        exp_t        e;
        int          t, bi;
        @(negedge clk);
        d = a - b;
        rst_n = !rst; if_pc = ipc; ex_valid = v; ex_pc = pc;
        ex_branch = br; ex_jump = jmp; ex_jalr = jr; ex_funct3 = f3;
        N = d[31]; Z = (a == b); C = (a >= b);
        V = (a[31] != b[31]) && (d[31] != a[31]);
        ex_pred_taken = ptk; ex_pred_target = ptg;
        ex_br_target = brt; ex_jalr_target = jrt; ex_pc_plus4 = pc + 4;

        case (f3)
            3'd0:    cnd = (a == b);
            3'd1:    cnd = (a != b);
            3'd4:    cnd = ($signed(a) < $signed(b));
            3'd5:    cnd = ($signed(a) >= $signed(b));
            3'd6:    cnd = (a < b);
            3'd7:    cnd = (a >= b);
            default: cnd = 0;
        endcase
        ctrl = br || jmp || jr;
        at   = (br && cnd) || jmp || jr;
        atg  = jr ? jrt : brt;
        fl   = ctrl && ((at != ptk) || (at && ptk && (ptg != atg)));

        e = '{rst: rst, pt: 0, ptg: 0, bt: 0, ps: 0, fl: 0, rp: 0, bc: m_bc, mc: m_mc};
        if (!rst) begin
            model_pred(ipc, e.pt, e.ptg);
            if (v) begin
                e.bt = br && cnd;
                e.ps = (jmp || (br && cnd)) ? 2'b01 : (jr ? 2'b10 : 2'b00);
                e.fl = fl;
                e.rp = at ? atg : pc + 4;
            end
        end
        q.push_back(e);

        if (rst) begin
            model_reset();
        end else if (v) begin
            bi = (pc / 4) % 64;
            t  = (pc / 4) % 16;
            if (br) m_bht[bi] = cnd ? ((m_bht[bi] < 3) ? m_bht[bi] + 1 : 3)
                                    : ((m_bht[bi] > 0) ? m_bht[bi] - 1 : 0);
            if ((br && cnd) || jmp) begin
                m_v[t] = 1; m_pc[t] = pc; m_tg[t] = brt; m_j[t] = jmp;
            end
            if (ctrl && m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 1;
            if (fl && m_mc != 32'hFFFF_FFFF) m_mc = m_mc + 1;
        end
    endtask

    task automatic idle(input logic [31:0] ipc);
        step(0, ipc, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [31:0] pick_pc();
        return (($urandom_range(0, 3) == 0) ? 32'h8000 : 32'h0) + 32'h100 + 4 * $urandom_range(0, 31);
    endfunction

    // Monitor: compares whatever the driver expects for the current cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pred_taken", 32'(pred_taken), 32'(e.pt));
                chk("pred_target", pred_target, e.ptg);
                chk("btaken", 32'(btaken), 32'(e.bt));
                chk("pc_src", 32'(pc_src), 32'(e.ps));
                chk("flush", 32'(flush), 32'(e.fl));
                chk("redirect_pc", redirect_pc, e.rp);
                if (!e.rst) begin
                    chk("br_count", br_count, e.bc);
                    chk("mp_count", mp_count, e.mc);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Driver: directed scenarios first, then randomized traffic.
    initial begin
        bit          ptk, br, jmp, jr, v;
        logic [31:0] ptg, pc, ipc;
        int          kind;
        rst_n = 0; if_pc = 0; ex_valid = 0; ex_pc = 0; ex_branch = 0; ex_jump = 0;
        ex_jalr = 0; ex_funct3 = 0; N = 0; Z = 0; C = 0; V = 0; ex_pred_taken = 0;
        ex_pred_target = 0; ex_br_target = 0; ex_jalr_target = 0; ex_pc_plus4 = 0;
        model_reset();

        step(1, 32'h100, 1, 32'h100, 1, 0, 0, 3'd0, 5, 5, 0, 0, 32'h0F0, 0);
        step(1, 32'h140, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(32'h100);
        // Loop branch: taken beq, then lookup at the branch PC.
        step(0, 32'h200, 1, 32'h100, 1, 0, 0, 3'd0, 5, 5, 0, 0, 32'h0F0, 0);
        idle(32'h100);
        // Saturate, then two not-taken outcomes.
        for (int i = 0; i < 5; i++)
            step(0, 32'h100, 1, 32'h100, 1, 0, 0, 3'd0, 9, 9, 1, 32'h0F0, 32'h0F0, 0);
        step(0, 32'h100, 1, 32'h100, 1, 0, 0, 3'd0, 9, 3, 1, 32'h0F0, 32'h0F0, 0);
        idle(32'h100);
        step(0, 32'h100, 1, 32'h100, 1, 0, 0, 3'd0, 9, 3, 1, 32'h0F0, 32'h0F0, 0);
        idle(32'h100);
        // Unsigned compares against zero.
        step(0, 32'h0, 1, 32'h180, 1, 0, 0, 3'd6, 7, 0, 0, 0, 32'h1C0, 0);
        step(0, 32'h0, 1, 32'h184, 1, 0, 0, 3'd7, 7, 0, 0, 0, 32'h1C0, 0);
        // jalr: flushes and never allocates.
        step(0, 32'h0, 1, 32'h300, 0, 0, 1, 3'd0, 0, 0, 0, 0, 32'h400, 32'h2000);
        idle(32'h300);
        // Aliasing jal pair.
        step(0, 32'h0, 1, 32'h100, 0, 1, 0, 3'd0, 0, 0, 0, 0, 32'h500, 0);
        idle(32'h100);
        step(0, 32'h0, 1, 32'h140, 0, 1, 0, 3'd0, 0, 0, 0, 0, 32'h600, 0);
        idle(32'h100);
        idle(32'h140);

        for (int n = 0; n < 600; n++) begin
            pc   = pick_pc();
            ipc  = ($urandom_range(0, 2) == 0) ? pc : pick_pc();
            kind = $urandom_range(0, 9);
            br   = (kind < 5);
            jmp  = (kind == 5 || kind == 6);
            jr   = (kind == 7);
            v    = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 1) == 1) model_pred(pc, ptk, ptg);
            else begin
                ptk = 1'($urandom_range(0, 1));
                ptg = pick_pc();
            end
            step(($urandom_range(0, 63) == 0), ipc, v, pc, br, jmp, jr,
                 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) == 0) ? 32'h8000_0000 + $urandom_range(0, 3) : $urandom_range(0, 7),
                 ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE + $urandom_range(0, 1) : $urandom_range(0, 7),
                 ptk, ptg, pick_pc(), pick_pc() & 32'hFFFF_FFFE);
        end

        repeat (2) @(negedge clk);
        #3;
        chk("scoreboard_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
